// File: rtl/pose_judge.sv
// Pose-matching game judge: debounces the player's arm buttons, compares the
// resulting pose to the boss pose within a timed window and emits hit pulses.
module pose_judge #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int WINDOW_CYC   = 100000000,
  parameter int PULSE_LEN    = 4,
  parameter int SETTLE_CYC   = 1000,
  parameter int MAX_MISS     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left_btn,
  input  logic       right_btn,
  input  logic       start,
  input  logic [1:0] boss_pose,
  output logic       right,
  output logic [7:0] score,
  output logic [3:0] miss_count,
  output logic       game_over,
  output logic       round_active
);

  localparam int DB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam int CNT_MAX_A = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > PULSE_LEN) ? CNT_MAX_A : PULSE_LEN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HIT, S_SETTLE, S_OVER} state_t;

  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_db;
  assign w_btn_raw = {left_btn, right_btn};

  // Bit 1 is the left arm, bit 0 the right arm, matching the boss_pose encoding.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_db;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_db  <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_btn_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 != r_db) begin
            if (r_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
              r_db  <= r_s2;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + DB_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_btn_db[gi] = r_db;
    end
  endgenerate

  logic r_start_s1;
  logic r_start_s2;
  logic r_start_d;
  logic w_start_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
    end
  end

  assign w_start_ev = r_start_s2 & ~r_start_d;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       r_score;
  logic [7:0]       w_score_next;
  logic [3:0]       r_miss;
  logic [3:0]       w_miss_next;
  logic [3:0]       w_miss_inc;
  logic [1:0]       r_hit_pose;
  logic [1:0]       w_hit_pose_next;
  logic             r_right;
  logic             r_game_over;
  logic             r_round_active;

  assign w_miss_inc = r_miss + 4'd1;

  // r_cnt is the window timer in WAIT, the pulse length in HIT and the settle
  // wait in SETTLE; every state transition clears it.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_score_next    = r_score;
    w_miss_next     = r_miss;
    w_hit_pose_next = r_hit_pose;
    case (r_state)
      S_IDLE: begin
        if (w_start_ev) begin
          w_state_next = S_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (w_btn_db == boss_pose) begin
          w_state_next    = S_HIT;
          w_cnt_next      = '0;
          w_hit_pose_next = boss_pose;
          w_score_next    = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
        end else if (r_cnt == CNT_W'(WINDOW_CYC - 1)) begin
          w_cnt_next  = '0;
          w_miss_next = w_miss_inc;
          if (w_miss_inc == 4'(MAX_MISS)) begin
            w_state_next = S_OVER;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HIT: begin
        if (r_cnt == CNT_W'(PULSE_LEN - 1)) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if ((boss_pose != r_hit_pose) || (r_cnt == CNT_W'(SETTLE_CYC - 1))) begin
          w_state_next = S_WAIT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_OVER: begin
        if (w_start_ev) begin
          w_state_next = S_WAIT;
          w_cnt_next   = '0;
          w_score_next = 8'd0;
          w_miss_next  = 4'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_score        <= 8'd0;
      r_miss         <= 4'd0;
      r_hit_pose     <= 2'b00;
      r_right        <= 1'b0;
      r_game_over    <= 1'b0;
      r_round_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_score        <= w_score_next;
      r_miss         <= w_miss_next;
      r_hit_pose     <= w_hit_pose_next;
      r_right        <= (w_state_next == S_HIT);
      r_game_over    <= (w_state_next == S_OVER);
      r_round_active <= (w_state_next == S_WAIT);
    end
  end

  assign right        = r_right;
  assign score        = r_score;
  assign miss_count   = r_miss;
  assign game_over    = r_game_over;
  assign round_active = r_round_active;

endmodule
